// File: rtl/fifo_bus_pkg.sv
// Shared types and widths for the FIFO-to-bus read path.
package fifo_bus_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned TIMER_W       = 8;
  localparam int unsigned RETRY_W       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    BACKOFF = 2'd2
  } drain_state_t;

endpackage

// File: rtl/fifo_bus_ack_timer.sv
// Ack timeout and retry bookkeeping for one in-flight bus word.
module fifo_bus_ack_timer
  import fifo_bus_pkg::*;
#(
  parameter int unsigned ack_timeout = 8,
  parameter int unsigned max_retries = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  input  logic clear,
  output logic retry_o,
  output logic give_up_o
);

  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retries;
  logic               expire;

  // retries never exceeds max_retries, so inequality marks "budget left"
  always_comb begin
    expire    = start && !ack && (timer == TIMER_W'(ack_timeout - 1));
    retry_o   = expire && (retries != RETRY_W'(max_retries));
    give_up_o = expire && (retries == RETRY_W'(max_retries));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      timer   <= '0;
      retries <= '0;
    end else if (start && ack) begin
      timer   <= '0;
      retries <= '0;
    end else if (retry_o) begin
      timer   <= '0;
      retries <= retries + 1'b1;
    end else if (give_up_o) begin
      timer   <= '0;
      retries <= '0;
    end else if (start) begin
      timer   <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_bus_drainer.sv
// Pops FIFO words and drives them onto the bus with valid/ack, timeout retry and drop.
module fifo_bus_drainer
  import fifo_bus_pkg::*;
#(
  parameter int unsigned width       = DEFAULT_WIDTH,
  parameter int unsigned ack_timeout = 8,
  parameter int unsigned max_retries = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_pndng_i,
  input  logic [width-1:0] fifo_dato_i,
  output logic             fifo_pop_o,
  output logic [width-1:0] bus_dato_o,
  output logic             bus_valid_o,
  input  logic             bus_ack_i,
  output logic             bus_err_o,
  output logic [15:0]      sent_cnt_o,
  output logic [7:0]       drop_cnt_o
);

  drain_state_t state, next_state;
  logic         sending;
  logic         ack_hit;
  logic         retry;
  logic         give_up;

  fifo_bus_ack_timer #(
    .ack_timeout (ack_timeout),
    .max_retries (max_retries)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (sending),
    .ack       (bus_ack_i),
    .clear     (state == IDLE),
    .retry_o   (retry),
    .give_up_o (give_up)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (fifo_pndng_i) next_state = SEND;
      SEND: begin
        if (bus_ack_i)     next_state = fifo_pndng_i ? SEND : IDLE;
        else if (retry)    next_state = BACKOFF;
        else if (give_up)  next_state = IDLE;
      end
      BACKOFF: next_state = SEND;
      default: next_state = IDLE;
    endcase
  end

  // pop is gated by reset so a pending FIFO is not drained while held in reset
  always_comb begin
    sending    = (state == SEND);
    ack_hit    = sending && bus_ack_i;
    fifo_pop_o = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE:    fifo_pop_o = fifo_pndng_i;
        SEND:    fifo_pop_o = bus_ack_i && fifo_pndng_i;
        default: fifo_pop_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_dato_o  <= '0;
      bus_valid_o <= 1'b0;
      bus_err_o   <= 1'b0;
      sent_cnt_o  <= '0;
      drop_cnt_o  <= '0;
    end else begin
      bus_valid_o <= (next_state == SEND);
      bus_err_o   <= give_up;
      if (fifo_pop_o)
        bus_dato_o <= fifo_dato_i;
      if (ack_hit)
        sent_cnt_o <= sent_cnt_o + 1'b1;
      if (give_up && (drop_cnt_o != '1))
        drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_bus_drainer.sv
// Scoreboard bench: FIFO model feeds the drainer, monitor checks acked and dropped words.
module tb_fifo_bus_drainer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_pndng_i = 1'b0;
  logic [15:0] fifo_dato_i = '0;
  logic        fifo_pop_o;
  logic [15:0] bus_dato_o;
  logic        bus_valid_o;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_o;
  logic [15:0] sent_cnt_o;
  logic [7:0]  drop_cnt_o;

  logic        sat_reset = 1'b1;
  logic        sat_pop, sat_valid, sat_err;
  logic [15:0] sat_dato, sat_sent;
  logic [7:0]  sat_drop;

  int          total = 0;
  int          bad = 0;
  int          pop_count = 0;
  logic        pop_seen = 1'b0;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] drop_q[$];

  always #5 clk = ~clk;

  fifo_bus_drainer #(.width(16), .ack_timeout(8), .max_retries(3)) dut (
    .clk(clk), .reset(reset), .fifo_pndng_i(fifo_pndng_i), .fifo_dato_i(fifo_dato_i),
    .fifo_pop_o(fifo_pop_o), .bus_dato_o(bus_dato_o), .bus_valid_o(bus_valid_o),
    .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o), .sent_cnt_o(sent_cnt_o),
    .drop_cnt_o(drop_cnt_o)
  );

  fifo_bus_drainer #(.width(16), .ack_timeout(2), .max_retries(0)) u_sat (
    .clk(clk), .reset(sat_reset), .fifo_pndng_i(1'b1), .fifo_dato_i(16'h5A5A),
    .fifo_pop_o(sat_pop), .bus_dato_o(sat_dato), .bus_valid_o(sat_valid),
    .bus_ack_i(1'b0), .bus_err_o(sat_err), .sent_cnt_o(sat_sent),
    .drop_cnt_o(sat_drop)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // FIFO model: first-word-fall-through, advances on edges where pop was seen
  always @(negedge clk) pop_seen = fifo_pop_o;
  always @(posedge clk) begin
    #1;
    if (pop_seen && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_count++;
    end
    fifo_pndng_i = (fifo_q.size() != 0);
    fifo_dato_i  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0;
  end

  // monitor: every accepted or dropped word must match the scoreboard
  always @(negedge clk) begin
    if (bus_valid_o && bus_ack_i) begin
      if (exp_q.size() == 0) check("unexpected_ack_word", {16'h0, bus_dato_o}, 32'hFFFF_FFFF);
      else check("acked_word", bus_dato_o, exp_q.pop_front());
    end
    if (bus_err_o) begin
      if (drop_q.size() == 0) check("unexpected_drop", {16'h0, bus_dato_o}, 32'hFFFF_FFFF);
      else check("dropped_word", bus_dato_o, drop_q.pop_front());
    end
    if (fifo_pop_o) check("pop_needs_pndng", fifo_pndng_i, 1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [15:0] w, input bit acked);
    fifo_q.push_back(w);
    if (acked) exp_q.push_back(w);
    fifo_pndng_i = 1'b1;
    fifo_dato_i  = fifo_q[0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    pop_count = 0;
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || bus_valid_o) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL %s: drain did not finish within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] vpat;
    int         ones, falls, errs;
    logic       prev;

    // reset with a word already waiting
    bus_ack_i = 1'b1;
    push(16'h0006, 1);
    tick(3);
    check("rst_pop", fifo_pop_o, 0);
    check("rst_valid", bus_valid_o, 0);
    check("rst_dato", bus_dato_o, 0);
    check("rst_err", bus_err_o, 0);
    check("rst_sent", sent_cnt_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    reset = 1'b0;
    #1;
    check("first_pop", fifo_pop_o, 1);
    tick();
    check("first_valid", bus_valid_o, 1);
    check("first_dato", bus_dato_o, 16'h0006);
    tick();
    check("first_sent", sent_cnt_o, 1);

    // back-to-back acked words
    do_reset();
    push(16'h0006, 1);
    push(16'h000A, 1);
    tick();
    check("b2b_v0", bus_valid_o, 1);
    check("b2b_d0", bus_dato_o, 16'h0006);
    tick();
    check("b2b_v1", bus_valid_o, 1);
    check("b2b_d1", bus_dato_o, 16'h000A);
    tick();
    check("b2b_end_valid", bus_valid_o, 0);
    check("b2b_sent", sent_cnt_o, 2);
    check("b2b_pops", pop_count, 2);

    // one timeout, then ack on the resend
    do_reset();
    bus_ack_i = 1'b0;
    push(16'h00A5, 1);
    vpat = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vpat = {vpat[8:0], bus_valid_o};
    end
    check("retry_pattern", vpat, 10'b11111111_01);
    check("retry_dato", bus_dato_o, 16'h00A5);
    bus_ack_i = 1'b1;
    tick(2);
    check("retry_sent", sent_cnt_o, 1);
    check("retry_drop", drop_cnt_o, 0);
    check("retry_valid_after", bus_valid_o, 0);

    // retries exhausted: drop, then the next word is popped
    do_reset();
    bus_ack_i = 1'b0;
    push(16'h1234, 0);
    drop_q.push_back(16'h1234);
    push(16'h0BEE, 0);
    ones = 0; falls = 0; prev = 1'b0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (bus_valid_o) ones++;
      if (prev && !bus_valid_o) falls++;
      prev = bus_valid_o;
      check("drop_dato_stable", bus_dato_o, 16'h1234);
    end
    check("drop_valid_cycles", ones, 32);
    check("drop_gaps", falls, 3);
    tick();
    check("drop_err", bus_err_o, 1);
    check("drop_cnt", drop_cnt_o, 1);
    check("drop_valid_idle", bus_valid_o, 0);
    exp_q.push_back(16'h0BEE);
    tick();
    check("drop_err_once", bus_err_o, 0);
    check("next_valid", bus_valid_o, 1);
    check("next_dato", bus_dato_o, 16'h0BEE);
    bus_ack_i = 1'b1;
    tick(2);
    check("next_sent", sent_cnt_o, 1);

    // reset during the third valid cycle aborts silently
    do_reset();
    bus_ack_i = 1'b0;
    push(16'h00FF, 0);
    tick(3);
    check("abort_valid_before", bus_valid_o, 1);
    reset = 1'b1;
    tick();
    check("abort_valid", bus_valid_o, 0);
    check("abort_err", bus_err_o, 0);
    check("abort_sent", sent_cnt_o, 0);
    check("abort_drop", drop_cnt_o, 0);
    reset = 1'b0;
    bus_ack_i = 1'b1;
    tick(12);
    check("abort_no_resend", bus_valid_o, 0);
    check("abort_drop_after", drop_cnt_o, 0);
    check("abort_pops", pop_count, 1);

    // sent counter wrap
    do_reset();
    bus_ack_i = 1'b1;
    for (int i = 0; i < 65535; i++) push(16'(i), 1);
    wait_drained(70000, "wrap_drain");
    check("sent_ffff", sent_cnt_o, 16'hFFFF);
    push(16'hBEEF, 1);
    wait_drained(20, "wrap_last");
    check("sent_wrap", sent_cnt_o, 16'h0000);

    // drop counter saturation on the short-timeout instance
    sat_reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 1000 && errs < 257; i++) begin
      tick();
      if (sat_err) begin
        errs++;
        if (errs == 255) check("sat_at_255", sat_drop, 8'hFF);
      end
    end
    check("sat_err_pulses", errs, 257);
    tick();
    check("sat_hold_ff", sat_drop, 8'hFF);
    check("sat_sent_zero", sat_sent, 0);

    check("exp_q_empty", exp_q.size(), 0);
    check("drop_q_empty", drop_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_bus_drainer.md
Name: fifo_bus_drainer

Overview:
- Read-side companion to the project FIFO: watches the FIFO pending flag, pops words one at a time and drives each onto the shared bus with a valid/ack handshake.
- Recovers from missing acks with a timeout, bounded retries and a drop counter.
- Sits between one device's FIFO output and the bus interconnect; one instance per device.

Parameters:
- width, 16, data word width (matches the FIFO width).
- ack_timeout, 8, cycles bus_valid_o may stay high without bus_ack_i before a retry (range 2..255).
- max_retries, 3, retries after the first attempt before the word is dropped (range 0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_pndng_i  input  1  FIFO non-empty; fifo_dato_i holds the head word (first-word-fall-through).
- fifo_dato_i  input  width  FIFO head word.
- fifo_pop_o  output  1  one-cycle pop strobe; the FIFO advances on this clock edge.
- bus_dato_o  output  width  word presented to the bus.
- bus_valid_o  output  1  bus_dato_o is valid.
- bus_ack_i  input  1  bus accepted the word (sampled only while bus_valid_o=1).
- bus_err_o  output  1  one-cycle pulse when a word is dropped.
- sent_cnt_o  output  16  words acknowledged; wraps at 16'hFFFF.
- drop_cnt_o  output  8  words dropped; saturates at 8'hFF.

Behaviour:
- Reset (clk edge with reset=1), all outputs 0:
  - fifo_pop_o=0, bus_valid_o=0, bus_dato_o=0, bus_err_o=0, sent_cnt_o=0, drop_cnt_o=0.
  - Timer and retry counter cleared; FSM to IDLE.
- Reset mid-transfer aborts the word silently: no err pulse, no drop count.
- FSM states: IDLE, SEND, BACKOFF.
- IDLE:
  - If fifo_pndng_i=1: capture fifo_dato_i into hold register, assert fifo_pop_o for this cycle only, go to SEND.
  - Else stay.
- SEND:
  - bus_valid_o=1, bus_dato_o=hold register; both are registered.
  - The first bus_valid_o=1 cycle is the cycle after the pop.
  - bus_ack_i=1 in a cycle with bus_valid_o=1: sent_cnt_o+1, timer and retries cleared.
    - If fifo_pndng_i=1 in the same cycle: pop and capture the next word, stay in SEND (back-to-back, no bubble).
    - Else go to IDLE; bus_valid_o=0 next cycle.
  - No ack: timer+1. When timer reaches ack_timeout-1 without ack:
    - If retries<max_retries: retries+1, go to BACKOFF.
    - Else drop: bus_err_o=1 next cycle for one cycle, drop_cnt_o+1 (saturating), go to IDLE.
- BACKOFF:
  - Exactly one cycle with bus_valid_o=0, timer=0; then SEND with the same held word.
  - bus_dato_o holds its value during BACKOFF.
- Pop rules:
  - Never assert fifo_pop_o when fifo_pndng_i=0.
  - Never pop while holding an un-acked word, except the same-cycle ack+pop case above.
- bus_ack_i while bus_valid_o=0 is ignored.
- bus_dato_o is stable for the whole bus_valid_o=1 window.
- Counter widths:
  - sent_cnt_o is modular 16-bit.
  - drop_cnt_o saturates at 255.
  - Timer is 8-bit; retries counter is 4-bit.

Decomposition:
- Package fifo_bus_pkg:
  - typedef enum logic [1:0] {IDLE, SEND, BACKOFF} drain_state_t.
  - Localparams for timer and retry widths.
  - Default width constant shared with the FIFO.
- One natural sub-module: fifo_bus_ack_timer.
  - Holds the timeout and retry counters.
  - Inputs: start, ack, clear.
  - Outputs: retry_o, give_up_o.
- FSM and datapath stay in the top module.

Test Plan:
- Reset with FIFO holding 16'h0006 -> all outputs 0 during reset; first cycle after release pops; bus_valid_o=1 with bus_dato_o=16'h0006 the next cycle.
- FIFO holds 16'h0006, 16'h000A; bus acks each word in its first valid cycle -> pops on consecutive acked cycles with no valid gap; sent_cnt_o=2; fifo_pop_o asserted exactly twice.
- Single word 16'h00A5, ack_timeout=8, ack withheld 10 cycles then given -> valid high 8 cycles, one BACKOFF cycle with valid=0, resend 16'h00A5, ack accepted; sent_cnt_o=1, drop_cnt_o=0.
- Word 16'h1234, max_retries=3, ack never given -> 4 valid windows of 8 cycles separated by 1-cycle gaps; then bus_err_o pulses once, drop_cnt_o=1, returns to IDLE, next FIFO word popped.
- Reset asserted during the 3rd valid cycle of word 16'h00FF -> bus_valid_o=0 next cycle; counters 0; no bus_err_o; word not resent.
- sent_cnt_o preloaded via 65535 acked words, then one more -> sent_cnt_o wraps to 0; drop_cnt_o after 256 drops stays 8'hFF.
